// File: rtl/uart_tx_fifo_if.sv
// Byte-push / serial-line bundle between the DebugUnit and the UART transmitter.
// The DebugUnit side uses "master"; the transmitter uses "slave".
interface uart_tx_fifo_if #(
    parameter int FIFO_AW = 4
);
    logic               writeFlag;
    logic [7:0]         dataToSend;
    logic               uart_tx_start;
    logic               uart_tx;
    logic               uart_tx_done;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [FIFO_AW:0]   fifoCount;
    logic               overflow;

    modport master (
        output writeFlag, dataToSend, uart_tx_start,
        input  uart_tx, uart_tx_done, fifoFull, fifoEmpty, fifoCount, overflow
    );

    modport slave (
        input  writeFlag, dataToSend, uart_tx_start,
        output uart_tx, uart_tx_done, fifoFull, fifoEmpty, fifoCount, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular byte FIFO feeding a serialiser FSM.
// Frames run back-to-back while data is queued and the active-low start gate is low.
module uart_tx_fifo #(
    parameter int BAUD_DIV = 5208,
    parameter int FIFO_AW  = 4
) (
    input  logic          clock,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int               DEPTH      = 2 ** FIFO_AW;
    localparam logic [15:0]      BAUD_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] COUNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

    txState_e           stateReg, stateNext;
    logic [15:0]        baudReg, baudNext;
    logic [2:0]         bitReg, bitNext;
    logic [7:0]         shiftReg, shiftNext;
    logic               txReg, txNext;
    logic               doneReg;
    logic               overflowReg;
    logic [FIFO_AW-1:0] rdPtrReg, wrPtrReg;
    logic [FIFO_AW:0]   countReg, countNext;
    logic               fullReg, emptyReg;
    logic [7:0]         mem [DEPTH];

    logic pop;
    logic wrEn;
    logic canStart;
    logic lastTick;

    assign canStart = !emptyReg && !bus.uart_tx_start;
    assign lastTick = (baudReg == BAUD_LAST);
    // A full FIFO still takes a write when the serialiser frees a slot this cycle.
    assign wrEn     = bus.writeFlag && (!fullReg || pop);

    always_comb begin
        stateNext = stateReg;
        baudNext  = baudReg + 16'd1;
        bitNext   = bitReg;
        shiftNext = shiftReg;
        txNext    = 1'b1;
        pop       = 1'b0;
        unique case (stateReg)
            IDLE: begin
                baudNext = 16'd0;
                if (canStart) begin
                    pop       = 1'b1;
                    shiftNext = mem[rdPtrReg];
                    stateNext = START;
                    txNext    = 1'b0;
                end
            end
            START: begin
                txNext = 1'b0;
                if (lastTick) begin
                    stateNext = DATA;
                    baudNext  = 16'd0;
                    bitNext   = 3'd0;
                    txNext    = shiftReg[0];
                end
            end
            DATA: begin
                txNext = shiftReg[0];
                if (lastTick) begin
                    baudNext = 16'd0;
                    if (bitReg == 3'd7) begin
                        stateNext = STOP;
                        txNext    = 1'b1;
                    end else begin
                        bitNext   = bitReg + 3'd1;
                        shiftNext = shiftReg >> 1;
                        txNext    = shiftReg[1];
                    end
                end
            end
            STOP: begin
                if (lastTick) begin
                    baudNext = 16'd0;
                    if (canStart) begin
                        pop       = 1'b1;
                        shiftNext = mem[rdPtrReg];
                        stateNext = START;
                        txNext    = 1'b0;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        countNext = countReg;
        case ({wrEn, pop})
            2'b10:   countNext = countReg + COUNT_ONE;
            2'b01:   countNext = countReg - COUNT_ONE;
            default: countNext = countReg;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg    <= IDLE;
            baudReg     <= 16'd0;
            bitReg      <= 3'd0;
            shiftReg    <= 8'd0;
            txReg       <= 1'b1;
            doneReg     <= 1'b0;
            overflowReg <= 1'b0;
            rdPtrReg    <= '0;
            wrPtrReg    <= '0;
            countReg    <= '0;
            fullReg     <= 1'b0;
            emptyReg    <= 1'b1;
        end else begin
            stateReg    <= stateNext;
            baudReg     <= baudNext;
            bitReg      <= bitNext;
            shiftReg    <= shiftNext;
            txReg       <= txNext;
            // Registered so the pulse lands exactly on the last stop-bit cycle.
            doneReg     <= (stateNext == STOP) && (baudNext == BAUD_LAST);
            overflowReg <= bus.writeFlag && !wrEn;
            countReg    <= countNext;
            fullReg     <= (countNext == FULL_COUNT);
            emptyReg    <= (countNext == '0);
            if (wrEn) wrPtrReg <= wrPtrReg + PTR_ONE;
            if (pop)  rdPtrReg <= rdPtrReg + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (wrEn) mem[wrPtrReg] <= bus.dataToSend;
    end

    assign bus.uart_tx      = txReg;
    assign bus.uart_tx_done = doneReg;
    assign bus.fifoFull     = fullReg;
    assign bus.fifoEmpty    = emptyReg;
    assign bus.fifoCount    = countReg;
    assign bus.overflow     = overflowReg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: stimulus queues expected bytes, a line monitor decodes
// 8N1 frames and checks them (and done timing) against that queue.
module tb_uart_tx_fifo;
    localparam int B     = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 2 ** AW;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    byte  expQ[$];
    int   startTimes[$];
    int   doneTimes[$];
    bit   inFrame = 1'b0;
    int   frameStart = 0;

    uart_tx_fifo_if #(.FIFO_AW(AW)) bus ();

    uart_tx_fifo #(.BAUD_DIV(B), .FIFO_AW(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) nextCycle();
    endtask

    task automatic pushByte(input byte b, input bit expectAccept);
        bus.writeFlag  = 1'b1;
        bus.dataToSend = b;
        if (expectAccept) expQ.push_back(b);
        nextCycle();
        bus.writeFlag  = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (expQ.size() == 0 && !inFrame && bus.fifoEmpty === 1'b1) break;
            nextCycle();
        end
        check("idle_timeout", (i >= bound) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Line monitor: decodes frames at bit centres, compares against the expected queue.
    initial begin
        logic [7:0] acc;
        int off;
        bit expDone;
        acc = 8'h00;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                inFrame = 1'b0;
                continue;
            end
            if (!inFrame && bus.uart_tx === 1'b0) begin
                inFrame    = 1'b1;
                frameStart = cyc;
                startTimes.push_back(cyc);
            end
            off     = cyc - frameStart;
            expDone = inFrame && (off == 10 * B - 1);
            check("done_pulse", {31'd0, bus.uart_tx_done}, {31'd0, expDone});
            if (bus.uart_tx_done === 1'b1) doneTimes.push_back(cyc);
            if (inFrame) begin
                if (off == B / 2) check("start_bit", {31'd0, bus.uart_tx}, 32'd0);
                if (off >= B + B / 2 && off <= 8 * B + B / 2 && (off - B / 2) % B == 0)
                    acc[(off - B / 2) / B - 1] = bus.uart_tx;
                if (off == 9 * B + B / 2) check("stop_bit", {31'd0, bus.uart_tx}, 32'd1);
                if (off == 10 * B - 1) begin
                    if (expQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame_unexpected: got byte 0x%0h, expected no frame", acc);
                    end else begin
                        check("frame_byte", {24'd0, acc}, {24'd0, expQ.pop_front()});
                    end
                    inFrame = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1000000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        byte b;
        reset             = 1'b0;
        bus.writeFlag     = 1'b0;
        bus.dataToSend    = 8'h00;
        bus.uart_tx_start = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_tx", {31'd0, bus.uart_tx}, 32'd1);
        check("rst_done", {31'd0, bus.uart_tx_done}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_count", {29'd0, bus.fifoCount}, 32'd0);
        check("rst_empty", {31'd0, bus.fifoEmpty}, 32'd1);
        check("rst_full", {31'd0, bus.fifoFull}, 32'd0);
        nextCycle();
        reset = 1'b1;
        nextCycle();

        // Single byte latency and timing
        t0 = cyc;
        pushByte(8'hA5, 1'b1);
        @(negedge clock);
        check("lat_still_idle", {31'd0, bus.uart_tx}, 32'd1);
        waitCycle(t0 + 2);
        @(negedge clock);
        check("lat_start_low", {31'd0, bus.uart_tx}, 32'd0);
        waitCycle(t0 + 3);
        @(negedge clock);
        check("empty_after_pop", {31'd0, bus.fifoEmpty}, 32'd1);
        waitCycle(t0 + 41);
        @(negedge clock);
        check("single_done_c41", {31'd0, bus.uart_tx_done}, 32'd1);
        waitIdle(200);

        // Back-to-back frames
        startTimes.delete();
        doneTimes.delete();
        pushByte(8'h00, 1'b1);
        pushByte(8'hFF, 1'b1);
        waitIdle(300);
        check("b2b_starts", startTimes.size(), 32'd2);
        check("b2b_dones", doneTimes.size(), 32'd2);
        if (startTimes.size() == 2) check("b2b_start_gap", startTimes[1] - startTimes[0], 10 * B);
        if (doneTimes.size() == 2)  check("b2b_done_gap", doneTimes[1] - doneTimes[0], 10 * B);

        // Gate held while filling, then released
        bus.uart_tx_start = 1'b1;
        pushByte(8'h11, 1'b1);
        pushByte(8'h22, 1'b1);
        repeat (10) nextCycle();
        @(negedge clock);
        check("gate_tx_high", {31'd0, bus.uart_tx}, 32'd1);
        check("gate_count", {29'd0, bus.fifoCount}, 32'd2);
        bus.uart_tx_start = 1'b0;
        waitIdle(300);

        // Full / overflow with gate held
        bus.uart_tx_start = 1'b1;
        for (int i = 0; i < DEPTH; i++) pushByte(byte'(8'hC0 + i), 1'b1);
        @(negedge clock);
        check("full_after_fill", {31'd0, bus.fifoFull}, 32'd1);
        check("overflow_before", {31'd0, bus.overflow}, 32'd0);
        pushByte(8'hEE, 1'b0);
        @(negedge clock);
        check("overflow_pulse", {31'd0, bus.overflow}, 32'd1);
        check("overflow_count", {29'd0, bus.fifoCount}, DEPTH);
        nextCycle();
        @(negedge clock);
        check("overflow_one_cycle", {31'd0, bus.overflow}, 32'd0);
        bus.uart_tx_start = 1'b0;
        waitIdle(500);
        repeat (3 * 10 * B) nextCycle();

        // Gate raised mid-frame
        pushByte(8'h3C, 1'b1);
        pushByte(8'h5A, 1'b1);
        repeat (15) nextCycle();
        bus.uart_tx_start = 1'b1;
        repeat (60) nextCycle();
        @(negedge clock);
        check("midgate_tx_high", {31'd0, bus.uart_tx}, 32'd1);
        check("midgate_count", {29'd0, bus.fifoCount}, 32'd1);
        check("midgate_queued", expQ.size(), 32'd1);
        bus.uart_tx_start = 1'b0;
        waitIdle(300);

        // Asynchronous reset mid-frame
        pushByte(8'h77, 1'b1);
        pushByte(8'h88, 1'b1);
        repeat (15) nextCycle();
        #2;
        reset = 1'b0;
        #1;
        check("arst_tx", {31'd0, bus.uart_tx}, 32'd1);
        check("arst_count", {29'd0, bus.fifoCount}, 32'd0);
        check("arst_empty", {31'd0, bus.fifoEmpty}, 32'd1);
        expQ.delete();
        nextCycle();
        nextCycle();
        reset = 1'b1;
        repeat (12 * B) nextCycle();
        @(negedge clock);
        check("post_rst_tx_idle", {31'd0, bus.uart_tx}, 32'd1);
        check("post_rst_empty", {31'd0, bus.fifoEmpty}, 32'd1);

        // Randomised traffic with random gating
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 49) == 0) bus.uart_tx_start = ~bus.uart_tx_start;
            if (expQ.size() <= DEPTH - 1 && $urandom_range(0, 2) == 0) begin
                b = byte'($urandom_range(0, 255));
                pushByte(b, 1'b1);
            end else begin
                nextCycle();
            end
            @(negedge clock);
            check("rand_no_overflow", {31'd0, bus.overflow}, 32'd0);
        end
        bus.uart_tx_start = 1'b0;
        waitIdle(1000);
        repeat (10) nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
